// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with prescaler, edge/center-aligned counter,
// shadowed duty/mode registers that take effect at period boundaries.
module pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                wr_en,
    input  logic [3:0]          addr,
    input  logic [7:0]          wr_data,
    output logic [7:0]          rd_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    localparam logic [3:0]       ADDR_MASK     = 4'd8;
    localparam logic [3:0]       ADDR_PRESCALE = 4'd9;
    localparam logic [3:0]       ADDR_CTRL     = 4'd10;
    localparam logic [WIDTH-1:0] CNT_MAX       = '1;
    localparam logic [WIDTH-1:0] CNT_ONE       = WIDTH'(1);

    logic [WIDTH-1:0]    duty_shadow_q [CHANNELS];
    logic [WIDTH-1:0]    duty_shadow_d [CHANNELS];
    logic [WIDTH-1:0]    duty_active_q [CHANNELS];
    logic [WIDTH-1:0]    duty_active_d [CHANNELS];
    logic [CHANNELS-1:0] en_mask_q, en_mask_d;
    logic [7:0]          prescale_q, prescale_d;
    logic                mode_shadow_q, mode_shadow_d;
    logic                mode_active_q, mode_active_d;
    logic [7:0]          pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                dir_down_q, dir_down_d;
    logic                period_tick_q, period_tick_d;

    logic                wr_mask, wr_prescale, wr_ctrl, force_upd;
    logic                tick, boundary;
    logic [WIDTH-1:0]    cnt_step;
    logic                dir_step;

    assign wr_mask     = wr_en && (addr == ADDR_MASK);
    assign wr_prescale = wr_en && (addr == ADDR_PRESCALE);
    assign wr_ctrl     = wr_en && (addr == ADDR_CTRL);
    assign force_upd   = wr_ctrl && wr_data[1];
    assign tick        = ena && (pre_cnt_q == prescale_q);

    // Counter stepping; center mode visits MAX once and 0 once per period.
    always_comb begin
        cnt_step = cnt_q;
        dir_step = dir_down_q;
        boundary = 1'b0;
        if (tick) begin
            if (!mode_active_q) begin
                cnt_step = cnt_q + 1'b1;
                boundary = (cnt_q == CNT_MAX);
            end else if (!dir_down_q) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_step = cnt_q - 1'b1;
                    dir_step = 1'b1;
                end else begin
                    cnt_step = cnt_q + 1'b1;
                end
            end else begin
                cnt_step = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) begin
                    boundary = 1'b1;
                    dir_step = 1'b0;
                end
            end
        end
    end

    always_comb begin
        duty_shadow_d = duty_shadow_q;
        duty_active_d = duty_active_q;
        en_mask_d     = en_mask_q;
        prescale_d    = prescale_q;
        mode_shadow_d = mode_shadow_q;
        mode_active_d = mode_active_q;
        pre_cnt_d     = pre_cnt_q;
        cnt_d         = cnt_step;
        dir_down_d    = dir_step;
        period_tick_d = boundary;

        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && (addr == 4'(i))) begin
                duty_shadow_d[i] = wr_data[WIDTH-1:0];
            end
        end
        if (wr_mask) begin
            en_mask_d = wr_data[CHANNELS-1:0];
        end
        if (wr_prescale) begin
            prescale_d = wr_data;
        end
        if (wr_ctrl) begin
            mode_shadow_d = wr_data[0];
        end

        if (ena) begin
            pre_cnt_d = tick ? 8'd0 : pre_cnt_q + 8'd1;
        end
        if (wr_prescale) begin
            pre_cnt_d = 8'd0;
        end

        // Boundary loads the pre-write shadows, so a same-cycle write waits a period.
        if (boundary) begin
            duty_active_d = duty_shadow_q;
            mode_active_d = mode_shadow_q;
            cnt_d         = '0;
            dir_down_d    = 1'b0;
        end

        if (force_upd) begin
            duty_active_d = duty_shadow_q;
            mode_active_d = wr_data[0];
            cnt_d         = '0;
            pre_cnt_d     = 8'd0;
            dir_down_d    = 1'b0;
            period_tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_shadow_q[i] <= '0;
                duty_active_q[i] <= '0;
            end
            en_mask_q     <= '0;
            prescale_q    <= 8'd0;
            mode_shadow_q <= 1'b0;
            mode_active_q <= 1'b0;
            pre_cnt_q     <= 8'd0;
            cnt_q         <= '0;
            dir_down_q    <= 1'b0;
            period_tick_q <= 1'b0;
        end else begin
            duty_shadow_q <= duty_shadow_d;
            duty_active_q <= duty_active_d;
            en_mask_q     <= en_mask_d;
            prescale_q    <= prescale_d;
            mode_shadow_q <= mode_shadow_d;
            mode_active_q <= mode_active_d;
            pre_cnt_q     <= pre_cnt_d;
            cnt_q         <= cnt_d;
            dir_down_q    <= dir_down_d;
            period_tick_q <= period_tick_d;
        end
    end

    always_comb begin
        rd_data = 8'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (addr == 4'(i)) begin
                rd_data = 8'(duty_shadow_q[i]);
            end
        end
        case (addr)
            ADDR_MASK:     rd_data = 8'(en_mask_q);
            ADDR_PRESCALE: rd_data = prescale_q;
            ADDR_CTRL:     rd_data = {7'd0, mode_shadow_q};
            default:       ;
        endcase
    end

    always_comb begin
        pwm_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_out[i] = en_mask_q[i] && (cnt_q < duty_active_q[i]) && ena;
        end
    end

    assign period_tick = period_tick_q;

endmodule
